// File: rtl/fpu_operand_loader_if.sv
// Byte/operand/result bundle between the FPU operand loader and its neighbours.
// The slave modport is the loader's view; the master modport is the driver side.
interface fpu_operand_loader_if #(
  parameter int NUM_OPS  = 4,
  parameter int OP_WIDTH = 32
);
  localparam int FRAME_W = NUM_OPS * OP_WIDTH;
  localparam int CNT_W   = $clog2(FRAME_W / 8);

  logic [7:0]          byte_in;
  logic                byte_valid;
  logic                frame_start;
  logic [OP_WIDTH-1:0] res_in;
  logic [FRAME_W-1:0]  op_out;
  logic                op_valid;
  logic [OP_WIDTH-1:0] res_out;
  logic                res_valid;
  logic                busy;
  logic [CNT_W-1:0]    byte_count;
  logic                err;

  modport master (
    output byte_in, byte_valid, frame_start, res_in,
    input  op_out, op_valid, res_out, res_valid, busy, byte_count, err
  );

  modport slave (
    input  byte_in, byte_valid, frame_start, res_in,
    output op_out, op_valid, res_out, res_valid, busy, byte_count, err
  );
endinterface

// File: rtl/fpu_operand_loader.sv
// Framed byte-serial operand loader: 16 bytes -> 128-bit operand word, then waits
// LATENCY cycles and captures the FPU result. Define LOADER_TIMEOUT_EN to discard stale partial frames.
module fpu_operand_loader #(
  parameter int NUM_OPS  = 4,
  parameter int OP_WIDTH = 32,
  parameter int LATENCY  = 2,
  parameter int TIMEOUT  = 255
) (
  input  logic clk,
  input  logic rst_n,
  fpu_operand_loader_if.slave bus
);
  localparam int FRAME_W     = NUM_OPS * OP_WIDTH;
  localparam int FRAME_BYTES = FRAME_W / 8;
  localparam int CNT_W       = $clog2(FRAME_BYTES);

  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(FRAME_BYTES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [3:0]       WAIT_LAST = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_LAUNCH  = 2'd1,
    S_WAIT    = 2'd2
  } state_t;

  state_t              r_state;
  // The oldest byte of the frame is shifted out as the last one arrives, so only
  // FRAME_W-8 bits need storing; the completed word is {r_shift, byte_in}.
  logic [FRAME_W-9:0]  r_shift;
  logic [FRAME_W-1:0]  r_op_out;
  logic                r_op_valid;
  logic [OP_WIDTH-1:0] r_res_out;
  logic                r_res_valid;
  logic                r_busy;
  logic [CNT_W-1:0]    r_byte_count;
  logic                r_err;
  logic [3:0]          r_wait_cnt;

  state_t              w_state_next;
  logic [FRAME_W-9:0]  w_shift_next;
  logic [FRAME_W-1:0]  w_op_out_next;
  logic                w_op_valid_next;
  logic [OP_WIDTH-1:0] w_res_out_next;
  logic                w_res_valid_next;
  logic                w_busy_next;
  logic [CNT_W-1:0]    w_count_next;
  logic                w_err_next;
  logic [3:0]          w_wait_next;
  logic [FRAME_W-1:0]  w_word;
  logic [CNT_W-1:0]    w_count_base;

`ifdef LOADER_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);
  localparam logic [IDLE_W-1:0] IDLE_ONE  = IDLE_W'(1);

  logic [IDLE_W-1:0] r_idle_cnt;
  logic [IDLE_W-1:0] w_idle_next;
`endif

  always_comb begin
    w_state_next     = r_state;
    w_shift_next     = r_shift;
    w_op_out_next    = r_op_out;
    w_op_valid_next  = 1'b0;
    w_res_out_next   = r_res_out;
    w_res_valid_next = 1'b0;
    w_busy_next      = r_busy;
    w_count_next     = r_byte_count;
    w_err_next       = r_err;
    w_wait_next      = r_wait_cnt;
    w_word           = {r_shift, bus.byte_in};
    // A resync makes a same-cycle byte count as byte 0 of the new frame.
    w_count_base     = bus.frame_start ? '0 : r_byte_count;
`ifdef LOADER_TIMEOUT_EN
    w_idle_next      = r_idle_cnt;
`endif

    case (r_state)
      S_COLLECT: begin
        if (bus.frame_start) begin
          w_count_next = '0;
          w_err_next   = 1'b0;
        end
        if (bus.byte_valid) begin
          w_shift_next = w_word[FRAME_W-9:0];
          if (w_count_base == LAST_BYTE) begin
            w_op_out_next   = w_word;
            w_op_valid_next = 1'b1;
            w_busy_next     = 1'b1;
            w_count_next    = '0;
            w_state_next    = S_LAUNCH;
          end else begin
            w_count_next = w_count_base + CNT_ONE;
          end
        end
`ifdef LOADER_TIMEOUT_EN
        if (bus.byte_valid || bus.frame_start || (r_byte_count == '0)) begin
          w_idle_next = '0;
        end else if (r_idle_cnt == IDLE_LAST) begin
          w_idle_next  = '0;
          w_count_next = '0;
          w_shift_next = '0;
          w_err_next   = 1'b1;
        end else begin
          w_idle_next = r_idle_cnt + IDLE_ONE;
        end
`endif
      end

      S_LAUNCH: begin
        w_wait_next  = '0;
        w_state_next = S_WAIT;
        if (bus.byte_valid) w_err_next = 1'b1;
      end

      S_WAIT: begin
        if (bus.byte_valid) w_err_next = 1'b1;
        if (r_wait_cnt == WAIT_LAST) begin
          w_res_out_next   = bus.res_in;
          w_res_valid_next = 1'b1;
          w_busy_next      = 1'b0;
          w_state_next     = S_COLLECT;
        end else begin
          w_wait_next = r_wait_cnt + 4'd1;
        end
      end

      default: begin
        w_state_next = S_COLLECT;
        w_busy_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_COLLECT;
      r_shift      <= '0;
      r_op_out     <= '0;
      r_op_valid   <= 1'b0;
      r_res_out    <= '0;
      r_res_valid  <= 1'b0;
      r_busy       <= 1'b0;
      r_byte_count <= '0;
      r_err        <= 1'b0;
      r_wait_cnt   <= '0;
    end else begin
      r_state      <= w_state_next;
      r_shift      <= w_shift_next;
      r_op_out     <= w_op_out_next;
      r_op_valid   <= w_op_valid_next;
      r_res_out    <= w_res_out_next;
      r_res_valid  <= w_res_valid_next;
      r_busy       <= w_busy_next;
      r_byte_count <= w_count_next;
      r_err        <= w_err_next;
      r_wait_cnt   <= w_wait_next;
    end
  end

`ifdef LOADER_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_idle_cnt <= '0;
    else        r_idle_cnt <= w_idle_next;
  end
`endif

  assign bus.op_out     = r_op_out;
  assign bus.op_valid   = r_op_valid;
  assign bus.res_out    = r_res_out;
  assign bus.res_valid  = r_res_valid;
  assign bus.busy       = r_busy;
  assign bus.byte_count = r_byte_count;
  assign bus.err        = r_err;
endmodule

// File: tb/tb_fpu_operand_loader.sv
// Directed bench for fpu_operand_loader: framing, launch/result timing, overrun,
// resync, operand hold, idle timeout (behaviour follows LOADER_TIMEOUT_EN) and async reset.
module tb_fpu_operand_loader;
  localparam int LAT = 2;
  localparam int TO  = 8;
  localparam logic [127:0] FRAME_A = 128'h40000000_40400000_3FC00000_40000000;
  localparam logic [127:0] FRAME_B = 128'h3F800000_40000000_40400000_40800000;
  localparam logic [127:0] FRAME_R = 128'h12010203_04050607_08090A0B_0C0D0E0F;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fpu_operand_loader_if #(.NUM_OPS(4), .OP_WIDTH(32)) bus ();

  fpu_operand_loader #(
    .NUM_OPS(4), .OP_WIDTH(32), .LATENCY(LAT), .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  task automatic send_byte(input logic [7:0] b);
    bus.byte_in    = b;
    bus.byte_valid = 1'b1;
    @(negedge clk);
    bus.byte_valid = 1'b0;
    bus.byte_in    = 8'h00;
  endtask

  task automatic send_bytes(input logic [127:0] f, input int first, input int last, input bit gaps);
    logic [127:0] w;
    w = f;
    for (int i = first; i <= last; i++) begin
      send_byte(w[127-8*i -: 8]);
      if (gaps && (i % 3 == 1) && (i != last)) @(negedge clk);
    end
  endtask

  task automatic wait_res(output int cycles, output int ov_seen);
    cycles  = -1;
    ov_seen = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (bus.op_valid) ov_seen++;
      if (bus.res_valid) begin
        cycles = c;
        break;
      end
    end
  endtask

  task automatic test_reset;
    #1;
    n_checks++;
    if (bus.op_out !== 128'h0) begin n_fail++; $display("FAIL reset_op_out got=%h exp=0", bus.op_out); end
    n_checks++;
    if ({bus.op_valid, bus.res_valid, bus.busy, bus.err} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags got=%b exp=0000", {bus.op_valid, bus.res_valid, bus.busy, bus.err});
    end
    n_checks++;
    if (bus.byte_count !== 4'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", bus.byte_count); end
    n_checks++;
    if (bus.res_out !== 32'h0) begin n_fail++; $display("FAIL reset_res_out got=%h exp=0", bus.res_out); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    $display("reset: outputs cleared");
  endtask

  task automatic test_nominal;
    int cyc, ov;
    bus.res_in = 32'h41100000;
    send_byte(8'h40);
    n_checks++;
    if (bus.byte_count !== 4'd1) begin n_fail++; $display("FAIL nom_count1 got=%0d exp=1", bus.byte_count); end
    send_bytes(FRAME_A, 1, 15, 1'b1);
    n_checks++;
    if (bus.op_valid !== 1'b1) begin n_fail++; $display("FAIL nom_op_valid got=%b exp=1", bus.op_valid); end
    n_checks++;
    if (bus.op_out !== FRAME_A) begin n_fail++; $display("FAIL nom_op_out got=%h exp=%h", bus.op_out, FRAME_A); end
    n_checks++;
    if ({bus.busy, bus.byte_count} !== 5'b1_0000) begin
      n_fail++; $display("FAIL nom_busy_count got=%b/%0d exp=1/0", bus.busy, bus.byte_count);
    end
    wait_res(cyc, ov);
    n_checks++;
    if (cyc !== LAT + 1) begin n_fail++; $display("FAIL nom_res_latency got=%0d exp=%0d", cyc, LAT + 1); end
    n_checks++;
    if (ov !== 0) begin n_fail++; $display("FAIL nom_op_valid_pulse extra=%0d exp=0", ov); end
    n_checks++;
    if (bus.res_out !== 32'h41100000) begin n_fail++; $display("FAIL nom_res_out got=%h exp=41100000", bus.res_out); end
    n_checks++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL nom_busy_drop got=%b exp=0", bus.busy); end
    @(negedge clk);
    n_checks++;
    if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL nom_res_valid_pulse got=%b exp=0", bus.res_valid); end
    $display("nominal: op_out=%h res_out=%h latency=%0d", bus.op_out, bus.res_out, cyc);
  endtask

  task automatic test_operand_hold;
    int cyc, ov;
    logic [127:0] f;
    f = FRAME_B;
    bus.res_in = 32'h40C00000;
    for (int i = 0; i < 15; i++) begin
      send_byte(f[127-8*i -: 8]);
      n_checks++;
      if (bus.op_out !== FRAME_A) begin n_fail++; $display("FAIL hold_byte%0d got=%h exp=%h", i, bus.op_out, FRAME_A); end
    end
    send_byte(f[7:0]);
    n_checks++;
    if (bus.op_out !== FRAME_B) begin n_fail++; $display("FAIL hold_update got=%h exp=%h", bus.op_out, FRAME_B); end
    wait_res(cyc, ov);
    n_checks++;
    if (bus.res_out !== 32'h40C00000 || cyc !== LAT + 1) begin
      n_fail++; $display("FAIL hold_res got=%h@%0d exp=40c00000@%0d", bus.res_out, cyc, LAT + 1);
    end
    $display("operand_hold: op_out=%h held through collection", bus.op_out);
  endtask

  task automatic test_overrun;
    int cyc, ov;
    bus.res_in = 32'h41300000;
    send_bytes(FRAME_B, 0, 15, 1'b0);
    bus.byte_in    = 8'hAA;
    bus.byte_valid = 1'b1;
    @(negedge clk);
    bus.byte_valid = 1'b0;
    n_checks++;
    if (bus.err !== 1'b1) begin n_fail++; $display("FAIL ovr_err_set got=%b exp=1", bus.err); end
    n_checks++;
    if (bus.byte_count !== 4'd0) begin n_fail++; $display("FAIL ovr_count got=%0d exp=0", bus.byte_count); end
    wait_res(cyc, ov);
    n_checks++;
    if (cyc !== LAT || bus.res_out !== 32'h41300000) begin
      n_fail++; $display("FAIL ovr_res got=%h@%0d exp=41300000@%0d", bus.res_out, cyc, LAT);
    end
    bus.res_in = 32'h40800000;
    send_bytes(FRAME_A, 0, 15, 1'b0);
    n_checks++;
    if (bus.op_out !== FRAME_A) begin n_fail++; $display("FAIL ovr_next_frame got=%h exp=%h", bus.op_out, FRAME_A); end
    n_checks++;
    if (bus.err !== 1'b1) begin n_fail++; $display("FAIL ovr_err_sticky got=%b exp=1", bus.err); end
    wait_res(cyc, ov);
    bus.frame_start = 1'b1;
    @(negedge clk);
    bus.frame_start = 1'b0;
    n_checks++;
    if (bus.err !== 1'b0) begin n_fail++; $display("FAIL ovr_err_clear got=%b exp=0", bus.err); end
    $display("overrun: 0xAA dropped, err set then cleared by frame_start");
  endtask

  task automatic test_resync;
    int cyc, ov;
    bus.res_in = 32'h3F800000;
    send_bytes(FRAME_B, 0, 4, 1'b0);
    n_checks++;
    if (bus.byte_count !== 4'd5) begin n_fail++; $display("FAIL rsy_count5 got=%0d exp=5", bus.byte_count); end
    bus.frame_start = 1'b1;
    send_byte(8'h12);
    bus.frame_start = 1'b0;
    n_checks++;
    if (bus.byte_count !== 4'd1) begin n_fail++; $display("FAIL rsy_count1 got=%0d exp=1", bus.byte_count); end
    send_bytes(FRAME_R, 1, 15, 1'b0);
    n_checks++;
    if (bus.op_out[127:120] !== 8'h12) begin n_fail++; $display("FAIL rsy_msb got=%h exp=12", bus.op_out[127:120]); end
    n_checks++;
    if (bus.op_out !== FRAME_R || bus.op_valid !== 1'b1) begin
      n_fail++; $display("FAIL rsy_word got=%h/%b exp=%h/1", bus.op_out, bus.op_valid, FRAME_R);
    end
    wait_res(cyc, ov);
    n_checks++;
    if (cyc !== LAT + 1) begin n_fail++; $display("FAIL rsy_latency got=%0d exp=%0d", cyc, LAT + 1); end
    $display("resync: op_out=%h", bus.op_out);
  endtask

  task automatic test_timeout;
    logic [3:0] exp_count;
    logic       exp_err;
`ifdef LOADER_TIMEOUT_EN
    exp_count = 4'd0;
    exp_err   = 1'b1;
`else
    exp_count = 4'd3;
    exp_err   = 1'b0;
`endif
    send_bytes(FRAME_A, 0, 2, 1'b0);
    repeat (TO - 1) @(negedge clk);
    n_checks++;
    if (bus.byte_count !== 4'd3) begin n_fail++; $display("FAIL to_before got=%0d exp=3", bus.byte_count); end
    @(negedge clk);
    n_checks++;
    if (bus.byte_count !== exp_count) begin n_fail++; $display("FAIL to_count got=%0d exp=%0d", bus.byte_count, exp_count); end
    n_checks++;
    if (bus.err !== exp_err) begin n_fail++; $display("FAIL to_err got=%b exp=%b", bus.err, exp_err); end
    bus.frame_start = 1'b1;
    @(negedge clk);
    bus.frame_start = 1'b0;
    n_checks++;
    if ({bus.err, bus.byte_count} !== 5'b0_0000) begin
      n_fail++; $display("FAIL to_clear got=%b/%0d exp=0/0", bus.err, bus.byte_count);
    end
    $display("timeout: count=%0d err=%b after %0d idle cycles", exp_count, exp_err, TO);
  endtask

  task automatic test_reset_midwait;
    int cyc, ov;
    int rv_seen, busy_seen;
    bus.res_in = 32'h12345678;
    send_bytes(FRAME_A, 0, 15, 1'b0);
    bus.byte_in    = 8'hAA;
    bus.byte_valid = 1'b1;
    @(negedge clk);
    bus.byte_valid = 1'b0;
    n_checks++;
    if ({bus.err, bus.busy} !== 2'b11) begin n_fail++; $display("FAIL rst_pre got=%b exp=11", {bus.err, bus.busy}); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.op_out !== 128'h0 || bus.res_out !== 32'h0) begin
      n_fail++; $display("FAIL rst_async_data got=%h/%h exp=0/0", bus.op_out, bus.res_out);
    end
    n_checks++;
    if ({bus.busy, bus.err, bus.op_valid, bus.res_valid, bus.byte_count} !== 8'h00) begin
      n_fail++; $display("FAIL rst_async_ctrl got=%b exp=0", {bus.busy, bus.err, bus.op_valid, bus.res_valid, bus.byte_count});
    end
    @(negedge clk);
    rst_n = 1'b1;
    rv_seen   = 0;
    busy_seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.res_valid) rv_seen++;
      if (bus.busy) busy_seen++;
    end
    n_checks++;
    if (rv_seen !== 0 || busy_seen !== 0) begin
      n_fail++; $display("FAIL rst_no_result res_valid=%0d busy=%0d exp=0/0", rv_seen, busy_seen);
    end
    bus.res_in = 32'h40A00000;
    send_bytes(FRAME_B, 0, 15, 1'b0);
    n_checks++;
    if (bus.op_out !== FRAME_B) begin n_fail++; $display("FAIL rst_reload got=%h exp=%h", bus.op_out, FRAME_B); end
    wait_res(cyc, ov);
    n_checks++;
    if (bus.res_out !== 32'h40A00000 || cyc !== LAT + 1) begin
      n_fail++; $display("FAIL rst_reload_res got=%h@%0d exp=40a00000@%0d", bus.res_out, cyc, LAT + 1);
    end
    $display("reset_midwait: frame discarded, reload op_out=%h", bus.op_out);
  endtask

  initial begin
    bus.byte_in     = 8'h00;
    bus.byte_valid  = 1'b0;
    bus.frame_start = 1'b0;
    bus.res_in      = 32'h0;
    test_reset();
    test_nominal();
    test_operand_hold();
    test_overrun();
    test_resync();
    test_timeout();
    test_reset_midwait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fpu_operand_loader.md
# fpu_operand_loader

Byte-serial front end for the dual-multiply/add FPU datapath. It assembles a 16-byte frame into four 32-bit operands and presents them as one stable 128-bit word with a launch strobe. It then counts out the FPU pipeline latency and captures the 32-bit result with a one-cycle valid strobe for the downstream serializer. It replaces free-running byte collection with an explicitly framed, handshaked loader.

## Interface
- NUM_OPS, 4, number of 32-bit operands per frame
- OP_WIDTH, 32, operand width in bits; frame = NUM_OPS*OP_WIDTH/8 bytes (16)
- LATENCY, 2, cycles from op_out change to res_in valid; legal range 1..15
- TIMEOUT, 255, idle cycles before a partial frame is discarded (only with LOADER_TIMEOUT_EN)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset; asynchronous, active-low
- byte_in  in  8  frame byte
- byte_valid  in  1  byte_in is presented this cycle
- frame_start  in  1  synchronous frame resync
- res_in  in  32  FPU result
- op_out  out  128  operands; [127:96]=I4, [95:64]=I3, [63:32]=I2, [31:0]=I1
- op_valid  out  1  one-cycle launch strobe
- res_out  out  32  captured result
- res_valid  out  1  one-cycle result strobe
- busy  out  1  frame in flight; bytes not accepted
- byte_count  out  4  bytes held in the current partial frame
- err  out  1  sticky error flag

## Operation
- Reset (async, rst_n=0): state COLLECT; shift register, op_out, res_out, byte_count, wait counter, idle counter = 0; op_valid, res_valid, busy, err = 0.
- States: COLLECT -> LAUNCH -> WAIT -> COLLECT.
- COLLECT:
  - On byte_valid=1, shift byte_in into the LSB end of the 128-bit shift register and increment byte_count. The first byte of a frame ends in op_out[127:120] (I4 MSB).
  - When the 16th byte is accepted: op_out <= completed word, op_valid <= 1, busy <= 1, byte_count <= 0, state <= LAUNCH.
- frame_start in COLLECT:
  - byte_count <= 0 and err <= 0.
  - If byte_valid is high in the same cycle, that byte is accepted as byte 0.
- LAUNCH: lasts one cycle. op_valid <= 0, wait counter <= 0, state <= WAIT.
- WAIT:
  - Increment the wait counter each cycle.
  - When the count reaches LATENCY: res_out <= res_in, res_valid <= 1, busy <= 0, state <= COLLECT.
- res_valid deasserts the following cycle.
- op_out changes only on frame completion. It stays stable while the next frame is collected.
- byte_valid while busy=1: the byte is dropped and err <= 1.
- frame_start while busy=1: ignored.
- err clears only via frame_start in COLLECT, or reset.
- Reset asserted mid-frame or mid-WAIT: the frame is discarded immediately and no res_valid is issued.

## Timing
- Last byte accepted at edge k. Then:
  - op_out valid and op_valid=1 from k to k+1.
  - busy=1 from k to k+LATENCY+1.
  - res_in sampled at edge k+LATENCY+1; res_valid=1 from k+LATENCY+1 to k+LATENCY+2.
- A byte presented in the cycle after busy falls is accepted (edge k+LATENCY+2).
- Minimum frame period: 16+LATENCY+1 cycles.
- byte_count updates on the same edge that accepts a byte.
- All outputs are registered; no combinational input-to-output path.

## Configuration
- LOADER_TIMEOUT_EN defined:
  - An idle counter runs in COLLECT while byte_count>0 and byte_valid=0; any accepted byte clears it.
  - When it reaches TIMEOUT: byte_count <= 0, shift register <= 0, err <= 1.
- LOADER_TIMEOUT_EN undefined: no idle counter. A partial frame is held indefinitely, and err is set only by bytes dropped while busy.

## Test plan
- Reset: drive rst_n=0 mid-WAIT (after a launch). All outputs 0 asynchronously, no res_valid afterwards, byte_count=0.
- Nominal frame:
  - Send bytes 40 00 00 00 40 40 00 00 3F C0 00 00 40 00 00 00, back-to-back or with random gaps.
  - Expect op_out=0x40000000_40400000_3FC00000_40000000 with a single op_valid pulse.
  - Model res_in=0x41100000; expect res_out=0x41100000 and res_valid exactly LATENCY+1 cycles after op_valid.
- Overrun: drive byte_valid=1 with byte 0xAA while busy. Byte dropped, err=1; the next frame still loads correctly; frame_start clears err to 0.
- Resync: send 5 bytes, then frame_start with byte_valid=1 and byte 0x12. byte_count=1, and op_out[127:120]=0x12 after 15 more bytes.
- Operand hold: during collection of a second frame, op_out keeps the first frame's value until the 16th byte of the second frame.
- Timeout with TIMEOUT=8:
  - Macro defined: 3 bytes then 8 idle cycles gives byte_count=0 and err=1.
  - Macro undefined: byte_count stays 3 and err stays 0.
